// File: rtl/vtpu_instruction_issuer.sv
// Host-side sequencer: holds a program RAM and issues a contiguous run of
// instructions to the vTPU core, stalling on SYNC opcodes until the core retires them.
module vtpu_instruction_issuer #(
    parameter int          INSTR_WIDTH  = 80,
    parameter int          PROG_DEPTH   = 256,
    parameter logic [7:0]  SYNC_OPCODE  = 8'hFF,
    parameter int          SYNC_TIMEOUT = 65535
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          prog_write_en,
    input  logic [$clog2(PROG_DEPTH)-1:0] prog_write_address,
    input  logic [INSTR_WIDTH-1:0]        prog_write_data,
    input  logic                          start,
    input  logic [$clog2(PROG_DEPTH)-1:0] start_address,
    input  logic [15:0]                   instruction_count,
    input  logic                          abort,
    input  logic                          core_busy,
    input  logic                          core_synchronize,
    output logic [INSTR_WIDTH-1:0]        instruction_port,
    output logic                          instruction_enable,
    output logic                          running,
    output logic                          done,
    output logic                          sync_timeout_error,
    output logic [15:0]                   issued_count
);

    localparam int AW = $clog2(PROG_DEPTH);
    localparam int TW = $clog2(SYNC_TIMEOUT + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_ISSUE     = 3'd2;
    localparam logic [2:0] S_WAIT_SYNC = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    logic [2:0]             state;
    logic [2:0]             state_nxt;
    logic [INSTR_WIDTH-1:0] mem [PROG_DEPTH];
    logic [INSTR_WIDTH-1:0] rd_data;
    logic [AW-1:0]          address;
    logic [15:0]            remaining;
    logic [TW-1:0]          timer;
    logic                   accept;
    logic                   is_sync;
    logic                   timed_out;
    logic                   run_abort;
    logic                   start_ok;

    // Program RAM write port; independent of enable so the host can load at any time.
    always_ff @(posedge clk) begin
        if (prog_write_en) begin
            mem[prog_write_address] <= prog_write_data;
        end
    end

    // Read register only loads in FETCH, so the word stays stable through ISSUE
    // and a same-cycle write to the fetched address returns the old contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (enable && state == S_FETCH) begin
            rd_data <= mem[address];
        end
    end

    assign is_sync   = (rd_data[7:0] == SYNC_OPCODE);
    assign run_abort = abort && (state != S_IDLE);
    assign start_ok  = start && !abort && (state == S_IDLE);
    assign accept    = enable && (state == S_ISSUE) && !core_busy && !abort;
    assign timed_out = (timer == TW'(SYNC_TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        if (enable) begin
            if (run_abort) begin
                state_nxt = S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_ok) begin
                            state_nxt = (instruction_count == 16'd0) ? S_DONE : S_FETCH;
                        end
                    end
                    S_FETCH: state_nxt = S_ISSUE;
                    S_ISSUE: begin
                        if (accept) begin
                            if (is_sync) begin
                                state_nxt = S_WAIT_SYNC;
                            end else if (remaining == 16'd1) begin
                                state_nxt = S_DONE;
                            end else begin
                                state_nxt = S_FETCH;
                            end
                        end
                    end
                    S_WAIT_SYNC: begin
                        if (core_synchronize) begin
                            state_nxt = (remaining == 16'd0) ? S_DONE : S_FETCH;
                        end else if (timed_out) begin
                            state_nxt = S_DONE;
                        end
                    end
                    S_DONE:  state_nxt = S_IDLE;
                    default: state_nxt = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= S_IDLE;
            address            <= '0;
            remaining          <= '0;
            timer              <= '0;
            issued_count       <= '0;
            sync_timeout_error <= 1'b0;
        end else if (enable) begin
            state <= state_nxt;
            if (start_ok) begin
                address            <= start_address;
                remaining          <= instruction_count;
                issued_count       <= '0;
                sync_timeout_error <= 1'b0;
            end
            if (accept) begin
                address   <= address + 1'b1;
                remaining <= remaining - 16'd1;
                if (issued_count != '1) begin
                    issued_count <= issued_count + 16'd1;
                end
            end
            // Timer restarts on every entry into WAIT_SYNC; a sync in the timeout cycle wins.
            if (state != S_WAIT_SYNC) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
                if (!run_abort && !core_synchronize && timed_out) begin
                    sync_timeout_error <= 1'b1;
                end
            end
        end
    end

    assign instruction_port   = rd_data;
    assign instruction_enable = accept;
    assign running            = (state != S_IDLE);
    assign done               = enable && (state == S_DONE);

endmodule

// File: tb/tb_vtpu_instruction_issuer.sv
// Scoreboard bench for vtpu_instruction_issuer: expected issue order and run
// results come from a program-RAM model; a negedge monitor pops and compares.
module tb_vtpu_instruction_issuer;

    localparam int IW = 80;
    localparam int PD = 16;
    localparam int AW = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          prog_write_en;
    logic [AW-1:0] prog_write_address;
    logic [IW-1:0] prog_write_data;
    logic          start;
    logic [AW-1:0] start_address;
    logic [15:0]   instruction_count;
    logic          abort;
    logic          core_busy;
    logic          core_synchronize;
    logic [IW-1:0] instruction_port;
    logic          instruction_enable;
    logic          running;
    logic          done;
    logic          sync_timeout_error;
    logic [15:0]   issued_count;

    vtpu_instruction_issuer #(
        .INSTR_WIDTH (IW),
        .PROG_DEPTH  (PD),
        .SYNC_OPCODE (8'hFF),
        .SYNC_TIMEOUT(TO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .enable            (enable),
        .prog_write_en     (prog_write_en),
        .prog_write_address(prog_write_address),
        .prog_write_data   (prog_write_data),
        .start             (start),
        .start_address     (start_address),
        .instruction_count (instruction_count),
        .abort             (abort),
        .core_busy         (core_busy),
        .core_synchronize  (core_synchronize),
        .instruction_port  (instruction_port),
        .instruction_enable(instruction_enable),
        .running           (running),
        .done              (done),
        .sync_timeout_error(sync_timeout_error),
        .issued_count      (issued_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] cnt;
        logic        err;
    } done_t;

    int unsigned   cyc = 0;
    int            checks = 0;
    int            errors = 0;
    logic [IW-1:0] mem_m [PD];
    logic [IW-1:0] exp_q [$];
    done_t         done_q [$];
    int unsigned   en_log [$];
    int unsigned   done_log [$];
    bit            core_auto = 1'b0;
    bit            en_rand = 1'b0;
    int unsigned   sync_delay = 0;
    logic [IW-1:0] mon_e;
    done_t         mon_d;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chkw(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every accepted instruction and every done pulse is checked against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (instruction_enable) begin
                en_log.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chkw("unexpected_issue", instruction_port, '0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chkw("issue_data", instruction_port, mon_e);
                end
                if (core_auto && instruction_port[7:0] == 8'hFF) sync_delay = $urandom_range(1, 8);
            end
            if (done) begin
                done_log.push_back(cyc);
                if (done_q.size() == 0) begin
                    chki("unexpected_done", 1, 0);
                end else begin
                    mon_d = done_q.pop_front();
                    chki("done_issued_count", issued_count, mon_d.cnt);
                    chki("done_timeout_err", sync_timeout_error, mon_d.err);
                end
            end
        end
    end

    // Randomised core: back-pressure, delayed sync replies, and enable stalls.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (core_auto) begin
                core_busy = ($urandom_range(0, 2) == 0);
                enable = en_rand ? ($urandom_range(0, 9) != 0) : 1'b1;
                core_synchronize = 1'b0;
                if (sync_delay > 0 && enable) begin
                    sync_delay--;
                    if (sync_delay == 0) core_synchronize = 1'b1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IW-1:0] rand_word(input bit sync);
        logic [IW-1:0] w;
        w[31:0]  = $urandom;
        w[63:32] = $urandom;
        w[79:64] = 16'($urandom);
        if (sync) w[7:0] = 8'hFF;
        else if (w[7:0] == 8'hFF) w[7:0] = 8'h5A;
        return w;
    endfunction

    task automatic write_word(input logic [AW-1:0] a, input logic [IW-1:0] d);
        prog_write_en      = 1'b1;
        prog_write_address = a;
        prog_write_data    = d;
        mem_m[a]           = d;
        tick();
        prog_write_en = 1'b0;
    endtask

    task automatic pulse_start(input logic [AW-1:0] a, input logic [15:0] n, output int unsigned t);
        start             = 1'b1;
        start_address     = a;
        instruction_count = n;
        t                 = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic launch(input logic [AW-1:0] a, input logic [15:0] n, input logic err, output int unsigned t);
        done_t d;
        for (int unsigned i = 0; i < n; i++) exp_q.push_back(mem_m[AW'(a + i)]);
        d.cnt = n;
        d.err = err;
        done_q.push_back(d);
        pulse_start(a, n, t);
    endtask

    task automatic wait_done(input string name, input int unsigned budget);
        int unsigned k = 0;
        while (done_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        chki({name, "_finished"}, done_q.size(), 0);
        chki({name, "_all_issued"}, exp_q.size(), 0);
        done_q.delete();
        exp_q.delete();
    endtask

    task automatic clear_logs();
        en_log.delete();
        done_log.delete();
    endtask

    task automatic check_outputs_zero(input string name);
        chkw({name, "_port"}, instruction_port, '0);
        chki({name, "_enable"}, instruction_enable, 0);
        chki({name, "_running"}, running, 0);
        chki({name, "_done"}, done, 0);
        chki({name, "_err"}, sync_timeout_error, 0);
        chki({name, "_issued"}, issued_count, 0);
    endtask

    initial begin
        int unsigned t;
        int unsigned s;
        int unsigned k;
        logic [AW-1:0] ra;
        logic [15:0]   rn;

        rst = 1'b1; enable = 1'b1; prog_write_en = 1'b0; prog_write_address = '0;
        prog_write_data = '0; start = 1'b0; start_address = '0; instruction_count = '0;
        abort = 1'b0; core_busy = 1'b0; core_synchronize = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check_outputs_zero("reset");
        tick();
        rst = 1'b0;
        tick();

        // Basic 3-instruction run
        for (int unsigned i = 0; i < 3; i++) write_word(AW'(i), rand_word(1'b0));
        clear_logs();
        launch(4'd0, 16'd3, 1'b0, t);
        wait_done("t1", 50);
        chki("t1_num_issues", en_log.size(), 3);
        if (en_log.size() == 3) begin
            chki("t1_issue0_cycle", en_log[0], t + 2);
            chki("t1_issue1_cycle", en_log[1], t + 4);
            chki("t1_issue2_cycle", en_log[2], t + 6);
        end
        if (done_log.size() == 1) chki("t1_done_cycle", done_log[0], t + 7);
        else chki("t1_done_pulses", done_log.size(), 1);
        chki("t1_issued_count", issued_count, 3);

        // Back-pressure for 5 cycles from t+2
        clear_logs();
        launch(4'd0, 16'd3, 1'b0, t);
        tick();
        core_busy = 1'b1;
        for (int unsigned i = 0; i < 5; i++) begin
            @(negedge clk);
            chkw("t2_held_data", instruction_port, mem_m[0]);
            chki("t2_no_enable_busy", instruction_enable, 0);
            tick();
        end
        core_busy = 1'b0;
        wait_done("t2", 60);
        chki("t2_num_issues", en_log.size(), 3);
        if (en_log.size() > 0) chki("t2_first_issue_cycle", en_log[0], t + 7);

        // SYNC in the middle of a run
        write_word(4'd4, rand_word(1'b0));
        write_word(4'd5, rand_word(1'b1));
        write_word(4'd6, rand_word(1'b0));
        clear_logs();
        launch(4'd4, 16'd3, 1'b0, t);
        k = 0;
        while (en_log.size() < 2 && k < 50) begin
            tick();
            k++;
        end
        chki("t3_sync_issued", en_log.size(), 2);
        s = (en_log.size() >= 2) ? en_log[1] : cyc;
        repeat (9) tick();
        core_synchronize = 1'b1;
        tick();
        core_synchronize = 1'b0;
        wait_done("t3", 50);
        if (en_log.size() == 3) chki("t3_post_sync_cycle", en_log[2], s + 12);
        else chki("t3_num_issues", en_log.size(), 3);

        // Sync timeout, then same-cycle sync at the timeout boundary
        write_word(4'd8, rand_word(1'b1));
        clear_logs();
        launch(4'd8, 16'd1, 1'b1, t);
        wait_done("t4", 60);
        if (done_log.size() > 0) chki("t4_timeout_done_cycle", done_log[0], t + 3 + TO);
        tick();
        chki("t4_error_sticky", sync_timeout_error, 1);
        clear_logs();
        launch(4'd8, 16'd1, 1'b0, t);
        @(negedge clk);
        chki("t4_error_cleared_by_start", sync_timeout_error, 0);
        repeat (TO + 1) tick();
        core_synchronize = 1'b1;
        tick();
        core_synchronize = 1'b0;
        wait_done("t4b", 20);
        if (done_log.size() > 0) chki("t4b_done_cycle", done_log[0], t + 3 + TO);
        chki("t4b_no_error", sync_timeout_error, 0);

        // Address wrap and zero-length run
        write_word(4'd15, rand_word(1'b0));
        write_word(4'd0, rand_word(1'b0));
        clear_logs();
        launch(4'd15, 16'd2, 1'b0, t);
        wait_done("t5", 50);
        chki("t5_num_issues", en_log.size(), 2);
        clear_logs();
        launch(4'd3, 16'd0, 1'b0, t);
        wait_done("t5b", 10);
        if (done_log.size() > 0) chki("t5b_done_cycle", done_log[0], t + 1);
        chki("t5b_no_issue", en_log.size(), 0);

        // Abort in ISSUE after one acceptance
        clear_logs();
        exp_q.push_back(mem_m[0]);
        pulse_start(4'd0, 16'd3, t);
        repeat (3) tick();
        abort = 1'b1;
        @(negedge clk);
        chki("t6_abort_blocks_enable", instruction_enable, 0);
        tick();
        abort = 1'b0;
        @(negedge clk);
        chki("t6_idle_after_abort", running, 0);
        chki("t6_issued_kept", issued_count, 1);
        repeat (4) tick();
        chki("t6_no_done", done_log.size(), 0);
        chki("t6_issues_consumed", exp_q.size(), 0);

        // Reset mid-run
        exp_q.push_back(mem_m[0]);
        pulse_start(4'd0, 16'd3, t);
        repeat (2) tick();
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("t6_reset");
        tick();
        rst = 1'b0;
        tick();
        chki("t6_reset_issues_consumed", exp_q.size(), 0);
        exp_q.delete();

        // Randomised runs with back-pressure, sync replies and enable stalls
        core_auto = 1'b1;
        for (int unsigned r = 0; r < 25; r++) begin
            ra = AW'($urandom);
            rn = 16'($urandom_range(1, 10));
            for (int unsigned i = 0; i < rn; i++)
                write_word(AW'(ra + i), rand_word($urandom_range(0, 3) == 0));
            launch(ra, rn, 1'b0, t);
            en_rand = 1'b1;
            wait_done("rand", 1500);
            en_rand = 1'b0;
            tick();
        end
        core_auto = 1'b0;
        core_busy = 1'b0;
        core_synchronize = 1'b0;
        enable = 1'b1;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
